// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline register with a one-entry skid buffer so that in_ready is a
// pure register output and full throughput is kept while out_ready stays high.
module mem_wb_skid_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic              in_mem_r_en,
    input  logic [DEST_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_mem_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic [DEST_W-1:0] out_dest,
    output logic [DATA_W-1:0] out_wb_data,
    output logic [1:0]        occ
);

    logic              r_main_valid;
    logic              r_main_wb_en;
    logic [DEST_W-1:0] r_main_dest;
    logic [DATA_W-1:0] r_main_data;

    logic              r_skid_valid;
    logic              r_skid_wb_en;
    logic [DEST_W-1:0] r_skid_dest;
    logic [DATA_W-1:0] r_skid_data;

    logic              w_in_fire;
    logic              w_main_free;
    logic [DATA_W-1:0] w_in_data;

    // SKID only fills while MAIN is held, so SKID.valid alone means "full".
    assign w_in_fire   = in_valid & ~r_skid_valid;
    assign w_main_free = ~r_main_valid | out_ready;
    assign w_in_data   = in_mem_r_en ? in_mem_res : in_alu_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_wb_en <= 1'b0;
            r_main_dest  <= '0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_wb_en <= 1'b0;
            r_skid_dest  <= '0;
            r_skid_data  <= '0;
        end else if (flush) begin
            // Only the valid bits are dropped; payload registers keep their contents.
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_wb_en <= r_skid_wb_en;
                r_main_dest  <= r_skid_dest;
                r_main_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_main_valid <= 1'b1;
                r_main_wb_en <= in_wb_en;
                r_main_dest  <= in_dest;
                r_main_data  <= w_in_data;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid_valid <= 1'b1;
            r_skid_wb_en <= in_wb_en;
            r_skid_dest  <= in_dest;
            r_skid_data  <= w_in_data;
        end
    end

    assign in_ready    = ~r_skid_valid;
    assign out_valid   = r_main_valid;
    assign out_wb_en   = r_main_wb_en & r_main_valid;
    assign out_dest    = r_main_dest;
    assign out_wb_data = r_main_data;
    assign occ         = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Directed bench for mem_wb_skid_reg: a queue model checked every cycle plus
// literal expectations at each scenario step, and a 64-bit width instance.
module tb_mem_wb_skid_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_wb_en = 1'b0;
    logic        in_mem_r_en = 1'b0;
    logic [3:0]  in_dest = '0;
    logic [31:0] in_alu_res = '0;
    logic [31:0] in_mem_res = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_wb_en;
    logic [3:0]  out_dest;
    logic [31:0] out_wb_data;
    logic [1:0]  occ;

    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic        w_in_wb_en = 1'b0;
    logic        w_in_mem_r_en = 1'b0;
    logic [4:0]  w_in_dest = '0;
    logic [63:0] w_in_alu_res = '0;
    logic [63:0] w_in_mem_res = '0;
    logic        w_out_valid;
    logic        w_out_ready = 1'b0;
    logic        w_out_wb_en;
    logic [4:0]  w_out_dest;
    logic [63:0] w_out_wb_data;
    logic [1:0]  w_occ;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_skid_reg #(.DATA_W(32), .DEST_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_dest(in_dest),
        .in_alu_res(in_alu_res), .in_mem_res(in_mem_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_wb_en(out_wb_en),
        .out_dest(out_dest), .out_wb_data(out_wb_data), .occ(occ)
    );

    mem_wb_skid_reg #(.DATA_W(64), .DEST_W(5)) u_wide (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_wb_en(w_in_wb_en), .in_mem_r_en(w_in_mem_r_en), .in_dest(w_in_dest),
        .in_alu_res(w_in_alu_res), .in_mem_res(w_in_mem_res),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_wb_en(w_out_wb_en),
        .out_dest(w_out_dest), .out_wb_data(w_out_wb_data), .occ(w_occ)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: the stage is a FIFO of capacity 2; in_ready means "fewer than 2 held".
    typedef struct packed {
        logic        wb_en;
        logic [3:0]  dest;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];

    always @(posedge clk or negedge rst_n) begin
        int  sz;
        bit  in_f;
        bit  out_f;
        ent_t e;
        if (!rst_n) begin
            q.delete();
        end else begin
            sz    = q.size();
            in_f  = in_valid && (sz < 2);
            out_f = (sz > 0) && out_ready;
            e.wb_en = in_wb_en;
            e.dest  = in_dest;
            e.data  = in_mem_r_en ? in_mem_res : in_alu_res;
            if (flush) begin
                q.delete();
            end else begin
                if (out_f) void'(q.pop_front());
                if (in_f) q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_occ", {62'd0, occ}, 64'(q.size()));
            chk("model_in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
            chk("model_out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
            if (q.size() > 0) begin
                chk("model_out_wb_en", {63'd0, out_wb_en}, {63'd0, q[0].wb_en});
                chk("model_out_dest", {60'd0, out_dest}, {60'd0, q[0].dest});
                chk("model_out_wb_data", {32'd0, out_wb_data}, {32'd0, q[0].data});
            end else begin
                chk("model_wb_en_idle", {63'd0, out_wb_en}, 64'd0);
            end
        end
    end

    task automatic drive(input logic v, input logic wb, input logic rmem, input logic [3:0] dest,
                         input logic [31:0] alu, input logic [31:0] mem);
        in_valid    = v;
        in_wb_en    = wb;
        in_mem_r_en = rmem;
        in_dest     = dest;
        in_alu_res  = alu;
        in_mem_res  = mem;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [1:0] o,
                              input logic rdy, input logic [3:0] dest, input logic [31:0] data);
        chk({name, "_valid"}, {63'd0, out_valid}, {63'd0, v});
        chk({name, "_occ"}, {62'd0, occ}, {62'd0, o});
        chk({name, "_in_ready"}, {63'd0, in_ready}, {63'd0, rdy});
        if (v) begin
            chk({name, "_dest"}, {60'd0, out_dest}, {60'd0, dest});
            chk({name, "_data"}, {32'd0, out_wb_data}, {32'd0, data});
        end
        $display("step %s: out_valid=%0d occ=%0d in_ready=%0d dest=%0d data=%h",
                 name, out_valid, occ, in_ready, out_dest, out_wb_data);
    endtask

    task automatic expect_reset(input string name);
        chk({name, "_valid"}, {63'd0, out_valid}, 64'd0);
        chk({name, "_wb_en"}, {63'd0, out_wb_en}, 64'd0);
        chk({name, "_dest"}, {60'd0, out_dest}, 64'd0);
        chk({name, "_data"}, {32'd0, out_wb_data}, 64'd0);
        chk({name, "_occ"}, {62'd0, occ}, 64'd0);
        chk({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        $display("step %s: reset values observed", name);
    endtask

    initial begin
        step();
        step();
        expect_reset("reset");
        rst_n = 1'b1;

        // Pass-through: ALU result then a load, one cycle latency each.
        out_ready = 1'b1;
        drive(1, 1, 0, 4'd3, 32'h11, 32'h99);
        step();
        expect_out("pass_a", 1, 2'd1, 1, 4'd3, 32'h11);
        drive(1, 1, 1, 4'd5, 32'h77, 32'h22);
        step();
        expect_out("pass_b", 1, 2'd1, 1, 4'd5, 32'h22);
        drive(0, 0, 0, 4'd0, 32'h0, 32'h0);
        step();
        expect_out("pass_idle", 0, 2'd0, 1, 4'd0, 32'h0);

        // 64-bit / 5-bit instance, bit-exact load data.
        w_out_ready   = 1'b1;
        w_in_valid    = 1'b1;
        w_in_wb_en    = 1'b1;
        w_in_mem_r_en = 1'b1;
        w_in_dest     = 5'd31;
        w_in_alu_res  = 64'h0123_4567_89AB_CDEF;
        w_in_mem_res  = 64'hFFFF_FFFF_0000_0001;
        step();
        w_in_valid = 1'b0;
        chk("wide_valid", {63'd0, w_out_valid}, 64'd1);
        chk("wide_wb_en", {63'd0, w_out_wb_en}, 64'd1);
        chk("wide_dest", {59'd0, w_out_dest}, 64'd31);
        chk("wide_data", w_out_wb_data, 64'hFFFF_FFFF_0000_0001);
        $display("step wide: dest=%0d data=%h", w_out_dest, w_out_wb_data);

        // Backpressure: A, B fill the stage, C is held off.
        out_ready = 1'b0;
        drive(1, 1, 0, 4'd1, 32'hA1, 32'h0);
        step();
        expect_out("bp_a", 1, 2'd1, 1, 4'd1, 32'hA1);
        drive(1, 1, 0, 4'd2, 32'hB2, 32'h0);
        step();
        expect_out("bp_b", 1, 2'd2, 0, 4'd1, 32'hA1);
        drive(1, 1, 0, 4'd3, 32'hC3, 32'h0);
        step();
        expect_out("bp_c_held", 1, 2'd2, 0, 4'd1, 32'hA1);
        // Drain with C still pushing: MAIN takes SKID, C waits one more cycle.
        out_ready = 1'b1;
        step();
        expect_out("drain_b", 1, 2'd1, 1, 4'd2, 32'hB2);
        step();
        expect_out("drain_c", 1, 2'd1, 1, 4'd3, 32'hC3);
        drive(0, 0, 0, 4'd0, 32'h0, 32'h0);
        step();
        expect_out("drain_idle", 0, 2'd0, 1, 4'd0, 32'h0);

        // Entry with wb_en = 0 still occupies the stage.
        out_ready = 1'b0;
        drive(1, 0, 0, 4'd4, 32'hD4, 32'h0);
        step();
        expect_out("nowb_d", 1, 2'd1, 1, 4'd4, 32'hD4);
        chk("nowb_wb_en", {63'd0, out_wb_en}, 64'd0);
        drive(1, 1, 0, 4'd6, 32'hE6, 32'h0);
        step();
        expect_out("fl_full", 1, 2'd2, 0, 4'd4, 32'hD4);
        // Flush with a full stage and a pending input.
        flush = 1'b1;
        drive(1, 1, 0, 4'd9, 32'hF9, 32'h0);
        step();
        expect_out("flush_full", 0, 2'd0, 1, 4'd0, 32'h0);
        chk("flush_wb_en", {63'd0, out_wb_en}, 64'd0);
        flush = 1'b0;
        drive(0, 0, 0, 4'd0, 32'h0, 32'h0);
        out_ready = 1'b1;
        step();
        expect_out("flush_after", 0, 2'd0, 1, 4'd0, 32'h0);
        // Flush discards an input that actually fires in the same cycle.
        out_ready = 1'b0;
        drive(1, 1, 0, 4'd10, 32'h1A, 32'h0);
        step();
        expect_out("fl2_g", 1, 2'd1, 1, 4'd10, 32'h1A);
        flush = 1'b1;
        drive(1, 1, 0, 4'd11, 32'h1B, 32'h0);
        step();
        expect_out("fl2_flush", 0, 2'd0, 1, 4'd0, 32'h0);
        flush = 1'b0;
        drive(0, 0, 0, 4'd0, 32'h0, 32'h0);
        step();
        expect_out("fl2_after", 0, 2'd0, 1, 4'd0, 32'h0);

        // Sustained one-per-cycle stream.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, i[0], i[1], 4'(i + 2), 32'h100 + 32'(i), 32'h200 + 32'(i));
            step();
            expect_out("stream", 1, 2'd1, 1, 4'(i + 2), i[1] ? 32'h200 + 32'(i) : 32'h100 + 32'(i));
        end

        // Mixed pseudo-random traffic, checked by the model only.
        for (int i = 0; i < 200; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)), $urandom, $urandom);
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 19) == 0;
            step();
        end
        flush = 1'b0;

        // Async reset between edges with a full stage.
        out_ready = 1'b0;
        drive(1, 1, 0, 4'd12, 32'h12, 32'h0);
        step();
        drive(1, 1, 0, 4'd13, 32'h13, 32'h0);
        step();
        drive(1, 1, 0, 4'd14, 32'h14, 32'h0);
        step();
        chk("arst_pre_occ", {62'd0, occ}, 64'd2);
        #2;
        rst_n = 1'b0;
        drive(0, 0, 0, 4'd0, 32'h0, 32'h0);
        #1;
        expect_reset("arst");
        step();
        expect_reset("arst_hold");
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1, 1, 0, 4'd7, 32'hDEADBEEF, 32'h0);
        step();
        expect_out("arst_first", 1, 2'd1, 1, 4'd7, 32'hDEADBEEF);
        drive(0, 0, 0, 4'd0, 32'h0, 32'h0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_skid_reg.md
MEM_WB_SKID_REG -- requirements
Module: mem_wb_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the ALU-result, memory-result and write-back data paths.
REQ-002 Parameter DEST_W, default 4, width of the destination register index.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset; assertion clears state immediately, release takes effect synchronously to clk.
REQ-005 flush  input  1  synchronous discard of all held entries.
REQ-006 in_valid  input  1  upstream (MEM) entry present.
REQ-007 in_ready  output  1  stage can accept an entry this cycle.
REQ-008 in_wb_en, in_mem_r_en  input  1 each  write-back enable; load select.
REQ-009 in_dest  input  DEST_W  destination register index.
REQ-010 in_alu_res, in_mem_res  input  DATA_W each  ALU result; memory read data.
REQ-011 out_valid  output  1  output entry present.
REQ-012 out_ready  input  1  downstream (WB) consumes the output entry this cycle.
REQ-013 out_wb_en  output  1  stored wb_en AND out_valid.
REQ-014 out_dest  output  DEST_W  stored destination index.
REQ-015 out_wb_data  output  DATA_W  stored write-back value.
REQ-016 occ  output  2  number of held entries (0..2).

Function
REQ-017 Storage: two entries, MAIN (drives out_*) and SKID, each holding valid, wb_en, dest and wb_data.
REQ-018 Data select at capture: wb_data = in_mem_r_en ? in_mem_res : in_alu_res.
REQ-019 Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
REQ-020 in_ready = NOT SKID.valid, driven from a register with no combinational path from out_ready.
REQ-021 out_valid = MAIN.valid; out_dest/out_wb_data from MAIN fields.
REQ-022 MAIN empty or firing, SKID valid: MAIN <= SKID, SKID becomes empty.
REQ-023 MAIN empty or firing, SKID empty, input fire: MAIN <= input in the same edge (latency 1 cycle).
REQ-024 MAIN valid and not firing, input fire: SKID <= input; in_ready = 0 from the next cycle.
REQ-025 MAIN empty or firing with no new source: MAIN.valid <= 0.
REQ-026 Entry order is strict FIFO; no entry is dropped or duplicated unless flush or reset occurs.
REQ-027 Sustained throughput is 1 entry/cycle while out_ready = 1.
REQ-028 flush = 1: MAIN.valid and SKID.valid <= 0 and any same-cycle input fire is discarded; flush has priority over all other updates.
REQ-029 Data fields are not cleared by flush; out_wb_en is 0 whenever out_valid = 0.
REQ-030 occ = MAIN.valid + SKID.valid.
REQ-031 When MAIN.valid = 0, a captured entry with in_wb_en = 0 still occupies the stage and still handshakes normally.

Reset
REQ-032 While rst_n = 0: MAIN and SKID valid = 0; all data fields = 0; out_valid = 0, out_wb_en = 0, out_dest = 0, out_wb_data = 0, occ = 0, in_ready = 1.
REQ-033 Reset asserted mid-transfer discards all held entries with no partial update.
REQ-034 The first capture occurs on the first rising edge after rst_n rises with in_valid = 1.

Verification
REQ-035 Pass-through: out_ready = 1; inputs dest 3 with ALU 0x11, then dest 5 with a load of mem 0x22 -> out_dest/out_wb_data = 3/0x11 one cycle later, then 5/0x22 one cycle after that; occ stays at or below 1.
REQ-036 Backpressure: out_ready = 0; push A (dest 1), B (dest 2) -> occ = 2, in_ready = 0, C held off. Raise out_ready -> outputs in order A, B, C with no loss.
REQ-037 Skid drain with simultaneous push: occ = 2, out_ready = 1, in_valid = 1 -> MAIN <= SKID, input stalled that cycle; entry accepted on the next cycle.
REQ-038 Flush: occ = 2 and input firing, flush = 1 -> next cycle out_valid = 0, out_wb_en = 0, occ = 0, in_ready = 1; the flushed input never appears at the output.
REQ-039 Async reset: assert rst_n = 0 between clock edges with occ = 2 -> outputs clear immediately to the REQ-032 values; after release, accept dest 7 with ALU 0xDEADBEEF -> out_wb_data = 0xDEADBEEF.
REQ-040 Width: DATA_W = 64, DEST_W = 5; push dest 31 with a load of 0xFFFF_FFFF_0000_0001 -> the output matches bit-exact.
